// File: rtl/pin_entry_buffer.sv
// Keypad digit collector feeding comboLockStateMachine: assembles four hex digits,
// submits them with a fixed-length trig strobe. Optional macro PIN_AUTO_SUBMIT_EN.
module pin_entry_buffer #(
  parameter int TRIG_CYCLES    = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        keyValid,
  input  logic [3:0]  keyCode,
  input  logic        keyEnter,
  input  logic        keyClear,
  output logic [15:0] pinCode,
  output logic        trig,
  output logic [2:0]  digitCount,
  output logic        entryErr
);

  localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
  localparam logic [3:0]      TRIG_LAST = 4'(TRIG_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_FULL   = 2'd2,
    ST_SUBMIT = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [15:0]     pin_r, pin_s;
  logic [2:0]      count_r, count_s, count_inc_s;
  logic            trig_r, trig_s;
  logic            err_r, err_s;
  logic [3:0]      trig_cnt_r, trig_cnt_s;
  logic [TO_W-1:0] to_cnt_r, to_cnt_s;
  logic            valid_q_r, enter_q_r, clear_q_r;
  logic            valid_ev_s, enter_ev_s, clear_ev_s;

  assign valid_ev_s = keyValid & ~valid_q_r;
  assign enter_ev_s = keyEnter & ~enter_q_r;
  assign clear_ev_s = keyClear & ~clear_q_r;

  // Next-state and next-output logic; clear beats enter beats digit.
  always_comb begin
    state_s     = state_r;
    pin_s       = pin_r;
    count_s     = count_r;
    trig_s      = trig_r;
    err_s       = 1'b0;
    trig_cnt_s  = trig_cnt_r;
    to_cnt_s    = '0;
    count_inc_s = count_r + 3'd1;
    case (state_r)
      ST_IDLE, ST_ENTRY, ST_FULL: begin
        if (clear_ev_s) begin
          pin_s   = 16'h0000;
          count_s = 3'd0;
          state_s = ST_IDLE;
        end else if (enter_ev_s) begin
          if (state_r == ST_FULL) begin
            state_s    = ST_SUBMIT;
            trig_s     = 1'b1;
            trig_cnt_s = TRIG_LAST;
          end else begin
            err_s   = 1'b1;
            pin_s   = 16'h0000;
            count_s = 3'd0;
            state_s = ST_IDLE;
          end
        end else if (valid_ev_s) begin
          if (state_r == ST_FULL) begin
            err_s = 1'b1;
          end else begin
            pin_s   = (state_r == ST_IDLE) ? {12'h000, keyCode} : {pin_r[11:0], keyCode};
            count_s = count_inc_s;
            if (count_inc_s == 3'd4) begin
`ifdef PIN_AUTO_SUBMIT_EN
              state_s    = ST_SUBMIT;
              trig_s     = 1'b1;
              trig_cnt_s = TRIG_LAST;
`else
              state_s = ST_FULL;
`endif
            end else begin
              state_s = ST_ENTRY;
            end
          end
        end else if ((state_r != ST_IDLE) && (TIMEOUT_CYCLES != 0)) begin
          // Idle cycle inside a partial or full entry: count toward auto-clear.
          if (to_cnt_r == TO_LAST) begin
            err_s   = 1'b1;
            pin_s   = 16'h0000;
            count_s = 3'd0;
            state_s = ST_IDLE;
          end else begin
            to_cnt_s = to_cnt_r + TO_ONE;
          end
        end else begin
          to_cnt_s = '0;
        end
      end
      ST_SUBMIT: begin
        if (trig_cnt_r == 4'd0) begin
          trig_s  = 1'b0;
          count_s = 3'd0;
          state_s = ST_IDLE;
        end else begin
          trig_cnt_s = trig_cnt_r - 4'd1;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        pin_s      = 16'h0000;
        count_s    = 3'd0;
        trig_s     = 1'b0;
        trig_cnt_s = 4'd0;
      end
    endcase
  end

  // State, output and edge-detect registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      pin_r      <= 16'h0000;
      count_r    <= 3'd0;
      trig_r     <= 1'b0;
      err_r      <= 1'b0;
      trig_cnt_r <= 4'd0;
      to_cnt_r   <= '0;
      valid_q_r  <= 1'b0;
      enter_q_r  <= 1'b0;
      clear_q_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      pin_r      <= pin_s;
      count_r    <= count_s;
      trig_r     <= trig_s;
      err_r      <= err_s;
      trig_cnt_r <= trig_cnt_s;
      to_cnt_r   <= to_cnt_s;
      valid_q_r  <= keyValid;
      enter_q_r  <= keyEnter;
      clear_q_r  <= keyClear;
    end
  end

  assign pinCode    = pin_r;
  assign trig       = trig_r;
  assign digitCount = count_r;
  assign entryErr   = err_r;

endmodule
